// File: rtl/apb_cmd_bridge.sv
// Single-outstanding command-to-APB3 requester. One valid/ready command becomes one
// APB transfer; a bounded wait on pready turns a hung target into an error response.
module apb_cmd_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(32'hBADD_C0DE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timeout_q;
  logic              timeout_hit;

  // Handshakes: a transfer on either channel happens on a rising edge where valid and
  // ready are both high; rsp_valid and rsp_* hold until rsp_ready, cmd_ready is IDLE-only.
  assign timeout_hit = TO_EN && (wait_cnt == CNT_LAST) && !apb_pready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) state_d = SETUP;
      end
      SETUP: begin
        apb_psel = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        cap_write <= cmd_write;
        cap_addr  <= cmd_addr;
        cap_wdata <= cmd_write ? cmd_wdata : '0;
        wait_cnt  <= '0;
      end
      // Only the ACCESS phase samples pready, so a late pready in RESP is ignored.
      if (state_q == ACCESS) begin
        if (apb_pready) begin
          rdata_q   <= cap_write ? '0 : apb_prdata;
          err_q     <= apb_pslverr;
          timeout_q <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q   <= TO_DATA;
          err_q     <= 1'b1;
          timeout_q <= 1'b1;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  assign apb_pwrite  = cap_write;
  assign apb_paddr   = cap_addr;
  assign apb_pwdata  = cap_wdata;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = timeout_q;
  assign dbg_state   = state_q;

endmodule
